// File: rtl/demux1para2_5bit_reg.sv
// 1-to-2 demultiplexer for 5-bit words with a one-word registered slot per
// channel, valid/ready handshakes on both sides and per-channel acceptance counters.

module demux1para2_5bit_chan (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       drain,
  input  logic [4:0] din,
  output logic [4:0] data,
  output logic       valid,
  output logic [7:0] cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state_r;
  logic [4:0] data_r;
  logic [7:0] cnt_r;

  // Slot state, held word and acceptance count; drain only matters while FULL
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= EMPTY;
      data_r  <= 5'd0;
      cnt_r   <= 8'd0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (load) begin
            state_r <= FULL;
            data_r  <= din;
          end else begin
            state_r <= EMPTY;
          end
        end
        FULL: begin
          if (load) begin
            state_r <= FULL;
            data_r  <= din;
          end else if (drain) begin
            state_r <= EMPTY;
          end else begin
            state_r <= FULL;
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase
      if (load) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign data  = data_r;
  assign valid = (state_r == FULL);
  assign cnt   = cnt_r;

endmodule

module demux1para2_5bit_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] in_data,
  input  logic       in_valid,
  input  logic       sel,
  output logic       in_ready,
  output logic [4:0] out_a,
  output logic       out_a_valid,
  input  logic       out_a_ready,
  output logic [4:0] out_b,
  output logic       out_b_valid,
  input  logic       out_b_ready,
  output logic [7:0] cnt_a,
  output logic [7:0] cnt_b
);

  logic       in_ready_s;
  logic       load_a_s;
  logic       load_b_s;
  logic       a_valid_s;
  logic       b_valid_s;

  // Ready reflects only the addressed slot, so a stalled channel never blocks the other
  always_comb begin
    in_ready_s = 1'b0;
    if (sel) begin
      in_ready_s = !b_valid_s || out_b_ready;
    end else begin
      in_ready_s = !a_valid_s || out_a_ready;
    end
  end

  assign load_a_s = in_valid && in_ready_s && !sel;
  assign load_b_s = in_valid && in_ready_s && sel;

  demux1para2_5bit_chan u_chan_a (
    .clk   (clk),
    .reset (reset),
    .load  (load_a_s),
    .drain (out_a_ready),
    .din   (in_data),
    .data  (out_a),
    .valid (a_valid_s),
    .cnt   (cnt_a)
  );

  demux1para2_5bit_chan u_chan_b (
    .clk   (clk),
    .reset (reset),
    .load  (load_b_s),
    .drain (out_b_ready),
    .din   (in_data),
    .data  (out_b),
    .valid (b_valid_s),
    .cnt   (cnt_b)
  );

  assign in_ready    = in_ready_s;
  assign out_a_valid = a_valid_s;
  assign out_b_valid = b_valid_s;

endmodule

// File: tb/tb_demux1para2_5bit_reg.sv
// Self-checking bench for demux1para2_5bit_reg: directed scenarios plus a
// randomized run against a queue-based reference model of the two channels.

module tb_demux1para2_5bit_reg;

  logic       clk;
  logic       reset;
  logic [4:0] in_data;
  logic       in_valid;
  logic       sel;
  logic       in_ready;
  logic [4:0] out_a;
  logic       out_a_valid;
  logic       out_a_ready;
  logic [4:0] out_b;
  logic       out_b_valid;
  logic       out_b_ready;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;

  int total;
  int bad;

  // Reference model: each channel is a slot queue of capacity one
  logic [4:0] hold_a[$];
  logic [4:0] hold_b[$];
  logic [4:0] sent_a[$];
  logic [4:0] sent_b[$];
  logic [4:0] got_a[$];
  logic [4:0] got_b[$];
  int acc_a;
  int acc_b;

  demux1para2_5bit_reg dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .sel         (sel),
    .in_ready    (in_ready),
    .out_a       (out_a),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready),
    .out_b       (out_b),
    .out_b_valid (out_b_valid),
    .out_b_ready (out_b_ready),
    .cnt_a       (cnt_a),
    .cnt_b       (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_ready();
    if (sel) return (hold_b.size() == 0) || out_b_ready;
    return (hold_a.size() == 0) || out_a_ready;
  endfunction

  task automatic model_clear();
    hold_a.delete(); hold_b.delete();
    sent_a.delete(); sent_b.delete();
    got_a.delete();  got_b.delete();
    acc_a = 0; acc_b = 0;
  endtask

  // Advance one clock: update the model from current inputs, then let the edge pass
  task automatic tick();
    logic acc;
    acc = in_valid && model_ready();
    if (out_a_valid && out_a_ready) got_a.push_back(out_a);
    if (out_b_valid && out_b_ready) got_b.push_back(out_b);
    if (hold_a.size() != 0 && out_a_ready) void'(hold_a.pop_front());
    if (hold_b.size() != 0 && out_b_ready) void'(hold_b.pop_front());
    if (acc) begin
      if (sel) begin
        if (hold_b.size() != 0) void'(hold_b.pop_front());
        hold_b.push_back(in_data); sent_b.push_back(in_data); acc_b++;
      end else begin
        if (hold_a.size() != 0) void'(hold_a.pop_front());
        hold_a.push_back(in_data); sent_a.push_back(in_data); acc_a++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_data = 5'd0; sel = 1'b0;
    out_a_ready = 1'b0; out_b_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    total++;
    if ({out_a_valid, out_b_valid, out_a, out_b, cnt_a, cnt_b} !== 28'd0) begin
      bad++; $display("FAIL reset_outputs got av=%b bv=%b a=%h b=%h ca=%0d cb=%0d want all 0",
        out_a_valid, out_b_valid, out_a, out_b, cnt_a, cnt_b);
    end
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL reset_in_ready sel=%0d got %b want 1", s, in_ready);
      end
    end
  endtask

  task automatic test_routing();
    apply_reset();
    in_data = 5'h15; sel = 1'b0; in_valid = 1'b1; out_a_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL route_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0; out_a_ready = 1'b0;
    #1;
    total++;
    if (out_a !== 5'h15 || out_a_valid !== 1'b1) begin
      bad++; $display("FAIL route_out_a got %h/%b want 15/1", out_a, out_a_valid);
    end
    total++;
    if (out_b_valid !== 1'b0) begin bad++; $display("FAIL route_b_valid got %b want 0", out_b_valid); end
    total++;
    if (cnt_a !== 8'd1 || cnt_b !== 8'd0) begin
      bad++; $display("FAIL route_cnt got a=%0d b=%0d want 1/0", cnt_a, cnt_b);
    end
    out_a_ready = 1'b1;
    tick();
    out_a_ready = 1'b0;
    #1;
    total++;
    if (out_a_valid !== 1'b0 || out_a !== 5'h15) begin
      bad++; $display("FAIL route_drain got %h/%b want 15/0", out_a, out_a_valid);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    in_data = 5'h0A; sel = 1'b1; in_valid = 1'b1;
    tick();
    in_data = 5'h1F;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready got %b want 0", in_ready); end
    tick();
    total++;
    if (out_b !== 5'h0A || out_b_valid !== 1'b1 || cnt_b !== 8'd1) begin
      bad++; $display("FAIL bp_hold got %h/%b cnt=%0d want 0a/1 cnt=1", out_b, out_b_valid, cnt_b);
    end
    in_data = 5'h03; sel = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_other_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    total++;
    if (out_a !== 5'h03 || out_a_valid !== 1'b1 || out_b !== 5'h0A || cnt_a !== 8'd1) begin
      bad++; $display("FAIL bp_other_load got a=%h/%b b=%h ca=%0d want 03/1 0a 1",
        out_a, out_a_valid, out_b, cnt_a);
    end
  endtask

  task automatic test_drain_load();
    apply_reset();
    in_data = 5'h01; sel = 1'b0; in_valid = 1'b1;
    tick();
    out_a_ready = 1'b1; in_data = 5'h02;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL dl_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0; out_a_ready = 1'b0;
    #1;
    total++;
    if (out_a !== 5'h02 || out_a_valid !== 1'b1) begin
      bad++; $display("FAIL dl_out got %h/%b want 02/1", out_a, out_a_valid);
    end
    total++;
    if (got_a.size() != 1 || got_a[0] !== 5'h01) begin
      bad++; $display("FAIL dl_delivered got n=%0d want one delivery of 01", got_a.size());
    end
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    out_b_ready = 1'b1; sel = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = 5'($urandom);
      tick();
    end
    #1;
    total++;
    if (cnt_b !== 8'd0 || cnt_a !== 8'd0) begin
      bad++; $display("FAIL wrap_256 got b=%0d a=%0d want 0/0", cnt_b, cnt_a);
    end
    in_data = 5'($urandom);
    tick();
    in_valid = 1'b0;
    #1;
    total++;
    if (cnt_b !== 8'd1) begin bad++; $display("FAIL wrap_257 got %0d want 1", cnt_b); end
  endtask

  task automatic test_midstream_reset();
    apply_reset();
    in_valid = 1'b1; sel = 1'b0; in_data = 5'h11;
    tick();
    sel = 1'b1; in_data = 5'h12;
    tick();
    total++;
    if (out_a_valid !== 1'b1 || out_b_valid !== 1'b1) begin
      bad++; $display("FAIL mid_setup got av=%b bv=%b want 1/1", out_a_valid, out_b_valid);
    end
    out_a_ready = 1'b1; out_b_ready = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    total++;
    if ({out_a_valid, out_b_valid, out_a, out_b, cnt_a, cnt_b} !== 28'd0) begin
      bad++; $display("FAIL mid_async got av=%b bv=%b a=%h b=%h ca=%0d cb=%0d want all 0",
        out_a_valid, out_b_valid, out_a, out_b, cnt_a, cnt_b);
    end
    @(posedge clk);
    #2;
    total++;
    if ({out_a_valid, out_b_valid, cnt_a, cnt_b} !== 18'd0) begin
      bad++; $display("FAIL mid_edge got av=%b bv=%b ca=%0d cb=%0d want 0", out_a_valid, out_b_valid, cnt_a, cnt_b);
    end
    reset = 1'b0;
    model_clear();
    in_valid = 1'b0; out_a_ready = 1'b0; out_b_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_release_ready sel=%0d got %b want 1", s, in_ready); end
    end
    sel = 1'b0; in_valid = 1'b1; in_data = 5'h07;
    tick();
    in_valid = 1'b0;
    #1;
    total++;
    if (out_a !== 5'h07 || out_a_valid !== 1'b1 || cnt_a !== 8'd1 || cnt_b !== 8'd0) begin
      bad++; $display("FAIL mid_first got a=%h/%b ca=%0d cb=%0d want 07/1 1 0", out_a, out_a_valid, cnt_a, cnt_b);
    end
  endtask

  task automatic test_random_stress();
    logic exp_ready;
    apply_reset();
    for (int i = 0; i < 10000; i++) begin
      in_valid    = 1'($urandom_range(0, 1));
      sel         = 1'($urandom_range(0, 1));
      in_data     = 5'($urandom);
      out_a_ready = ($urandom_range(0, 3) != 0);
      out_b_ready = ($urandom_range(0, 2) == 0);
      #1;
      exp_ready = model_ready();
      total++;
      if (in_ready !== exp_ready) begin
        bad++; $display("FAIL stress_ready cyc=%0d got %b want %b", i, in_ready, exp_ready);
      end
      total++;
      if (out_a_valid !== (hold_a.size() != 0) || out_b_valid !== (hold_b.size() != 0)) begin
        bad++; $display("FAIL stress_valid cyc=%0d got a=%b b=%b want a=%0d b=%0d",
          i, out_a_valid, out_b_valid, hold_a.size(), hold_b.size());
      end
      if (hold_a.size() != 0) begin
        total++;
        if (out_a !== hold_a[0]) begin bad++; $display("FAIL stress_data_a cyc=%0d got %h want %h", i, out_a, hold_a[0]); end
      end
      if (hold_b.size() != 0) begin
        total++;
        if (out_b !== hold_b[0]) begin bad++; $display("FAIL stress_data_b cyc=%0d got %h want %h", i, out_b, hold_b[0]); end
      end
      total++;
      if (cnt_a !== 8'(acc_a) || cnt_b !== 8'(acc_b)) begin
        bad++; $display("FAIL stress_cnt cyc=%0d got a=%0d b=%0d want a=%0d b=%0d",
          i, cnt_a, cnt_b, acc_a % 256, acc_b % 256);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    total++;
    if (got_a.size() + hold_a.size() != sent_a.size() || got_b.size() + hold_b.size() != sent_b.size()) begin
      bad++; $display("FAIL stress_totals got a=%0d+%0d b=%0d+%0d want a=%0d b=%0d",
        got_a.size(), hold_a.size(), got_b.size(), hold_b.size(), sent_a.size(), sent_b.size());
    end
    for (int i = 0; i < got_a.size() && i < sent_a.size(); i++) begin
      total++;
      if (got_a[i] !== sent_a[i]) begin bad++; $display("FAIL stress_order_a idx=%0d got %h want %h", i, got_a[i], sent_a[i]); end
    end
    for (int i = 0; i < got_b.size() && i < sent_b.size(); i++) begin
      total++;
      if (got_b[i] !== sent_b[i]) begin bad++; $display("FAIL stress_order_b idx=%0d got %h want %h", i, got_b[i], sent_b[i]); end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    in_valid = 1'b0; in_data = 5'd0; sel = 1'b0;
    out_a_ready = 1'b0; out_b_ready = 1'b0;
    model_clear();
    test_reset();
    test_routing();
    test_backpressure();
    test_drain_load();
    test_counter_wrap();
    test_midstream_reset();
    test_random_stress();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux1para2_5bit_reg.md
DEMUX1PARA2_5BIT_REG -- requirements
Module: demux1para2_5bit_reg

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous active-high reset; clears all state immediately.
REQ-004 in_data  input  5  source word to be routed.
REQ-005 in_valid  input  1  in_data is offered this cycle.
REQ-006 sel  input  1  destination: 0 routes to channel A, 1 routes to channel B; sampled with in_data.
REQ-007 in_ready  output  1  the block accepts in_data this cycle.
REQ-008 out_a / out_b  output  5 each  registered data for channel A / channel B.
REQ-009 out_a_valid / out_b_valid  output  1 each  channel holds an undelivered word.
REQ-010 out_a_ready / out_b_ready  input  1 each  the consumer takes the channel word this cycle.
REQ-011 cnt_a / cnt_b  output  8 each  number of words accepted into channel A / channel B, modulo 256.

Function
REQ-012 Input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; output transfer on channel X SHALL occur on a rising edge with out_x_valid=1 and out_x_ready=1.
REQ-013 Each channel SHALL be a two-state machine: EMPTY (out_x_valid=0) and FULL (out_x_valid=1).
REQ-014 Channel transitions SHALL be: EMPTY->FULL on an input transfer addressed to it; FULL->EMPTY on an output transfer with no input transfer addressed to it; FULL->FULL on simultaneous output and input transfers, with the new word loaded; no change otherwise.
REQ-015 in_ready SHALL be combinational and equal to (!out_a_valid || out_a_ready) when sel=0, and (!out_b_valid || out_b_ready) when sel=1.
REQ-016 in_ready SHALL NOT depend on in_valid.
REQ-017 A word accepted at edge N SHALL appear on out_x with out_x_valid=1 after edge N, giving a latency of 1 cycle.
REQ-018 The unselected channel SHALL be unaffected by an input transfer: its data, valid and counter are unchanged.
REQ-019 While out_x_valid=1 and out_x_ready=0, out_x SHALL hold stable.
REQ-020 While out_x_valid=0, out_x SHALL retain the last loaded value.
REQ-021 out_x_ready SHALL be ignored while out_x_valid=0.
REQ-022 A FULL channel with out_x_ready=0 SHALL stall only inputs addressed to it; the other channel continues independently.
REQ-023 A word SHALL never be duplicated, dropped or delivered to the wrong channel.
REQ-024 cnt_x SHALL increment by 1 on each input transfer into channel X and wrap from 255 to 0.
REQ-025 Each channel sustains one transfer per cycle when its consumer holds out_x_ready=1.

Reset
REQ-026 While reset=1, the following SHALL hold asynchronously, independent of clk: out_a_valid=0, out_b_valid=0, out_a=0, out_b=0, cnt_a=0, cnt_b=0, and both channels EMPTY.
REQ-027 After reset, in_ready SHALL read 1 for either value of sel.
REQ-028 Reset asserted mid-operation SHALL discard held words, with no transfer completing on the edge coincident with reset.
REQ-029 The first accepting edge after reset deassertion SHALL behave as from power-up.

Verification
REQ-030 The bench SHALL cover reset/idle: assert reset mid-stream with both channels FULL -> all outputs 0 immediately without a clock edge; in_ready=1 after release.
REQ-031 The bench SHALL cover basic routing: in_data=5'h15, sel=0, in_valid=1, out_a_ready=1 -> out_a=5'h15 and out_a_valid=1 one cycle later; out_b_valid stays 0; cnt_a=1, cnt_b=0.
REQ-032 The bench SHALL cover backpressure: channel B FULL with 5'h0A and out_b_ready=0; offer 5'h1F with sel=1 -> in_ready=0, out_b holds 5'h0A; then offer 5'h03 with sel=0 -> accepted to A.
REQ-033 The bench SHALL cover simultaneous drain and load: channel A FULL with 5'h01, out_a_ready=1, in_data=5'h02, sel=0 -> in_ready=1, out_a=5'h02 next cycle, out_a_valid stays 1, and one delivery of 5'h01 is recorded.
REQ-034 The bench SHALL cover counter wrap: 256 accepted words into channel B -> cnt_b=0 and cnt_a unchanged; the 257th word -> cnt_b=1.
REQ-035 The bench SHALL cover randomized stress: random in_valid, sel and per-channel ready over 10,000 cycles -> a scoreboard shows in-order, lossless, correctly-routed delivery per channel, and count totals match cnt_a/cnt_b modulo 256.
